connect4_drop_ctrl: RTL and testbench
=====================================

# connect4_drop_ctrl

Parametrised column-select / token-drop controller for the Connect4 game core, generalising the fixed 4x4 column-select FSM to a ROWS x COLS board. It takes a debounced column selection plus a move strobe, computes the lowest free cell of that column, writes it for the player whose turn it is, and toggles the turn. It also rejects malformed or full-column moves, detects a full board (draw), and freezes on an externally reported game result. It sits between the input/keypad logic and the win checker / display drivers.

## Interface
- ROWS, 4, board rows (>=2); row 0 is the bottom row
- COLS, 4, board columns (>=2)
- N = ROWS*COLS (derived); CW = $clog2(N) (derived, min 1)
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately
- enable  in  1  move strobe, synchronous to clk; must be high across at least one rising edge
- in_column  in  COLS  active-low one-hot column select (exactly one bit 0 = valid)
- in_game_status  in  2  from win checker: 00 playing, 01 P1 won, 10 P2 won, 11 draw
- out_gameboard  out  N  occupancy; bit r*COLS+c = 1 when cell (r,c) holds a token
- out_players_cells  out  N  owner; bit = 1 for P2, 0 for P1; 0 wherever unoccupied
- out_game_status  out  2  latched game status (same encoding as input)
- current_state  out  2  FSM state: 00 IDLE, 01 CALC, 10 PLACE, 11 OVER
- playerTurn  out  1  0 = P1 to move, 1 = P2 to move
- column_calc  out  CW  cell index chosen/last written (r*COLS+c)
- out_move_ok  out  1  one-cycle pulse: a token was written
- out_move_rej  out  1  one-cycle pulse: move rejected (bad select or full column)
- out_col_full  out  COLS  bit c = 1 when column c has ROWS tokens

## Operation
- Per-column height counters h[c], width $clog2(ROWS+1); move counter width $clog2(N+1).
- enable is edge-detected internally (registered previous value); only a 0->1 transition triggers a move; holding enable high never retriggers.
- IDLE: on enable rise with in_game_status==00 -> CALC; latch in_column.
- CALC: valid iff latched column has exactly one 0 bit and h[c] < ROWS. Valid -> column_calc = h[c]*COLS+c, -> PLACE. Invalid -> out_move_rej pulse, -> IDLE, no state change otherwise.
- PLACE: set out_gameboard[column_calc]; set out_players_cells[column_calc] = playerTurn; h[c]++; move count++; toggle playerTurn; out_move_ok pulse. If move count reaches N -> out_game_status = 11, -> OVER; else -> IDLE.
- in_game_status != 00 sampled in IDLE or CALC: latch it into out_game_status, -> OVER; a move in CALC is aborted (no write, no pulse). In PLACE the write completes first, then -> OVER with the latched status.
- OVER: board, turn and status frozen; enable and in_column ignored; exit only via reset.
- out_col_full[c] = (h[c] == ROWS), combinational from counters.

## Timing
- Reset values: out_gameboard 0, out_players_cells 0, out_game_status 00, current_state 00, playerTurn 0, column_calc 0, out_move_ok 0, out_move_rej 0, out_col_full 0, all counters 0, enable history 0.
- Edge E0 samples enable rise -> CALC after E0; E1 -> PLACE (or reject pulse visible E1..E2); E2 writes board, out_move_ok high E2..E3, state IDLE after E2.
- Move-to-board latency: 2 cycles after sampling edge; max throughput one move per 3 cycles; an enable rise during CALC/PLACE is ignored (edge consumed).
- in_column must be stable on the sampling edge E0 only.
- Reset asserted mid-move: immediate clear; no partial write survives.

## Test plan
- Reset, enable pulse with in_column=1110 (col 0) -> after 2 cycles out_gameboard bit0=1, out_players_cells bit0=0, playerTurn=1, out_move_ok one pulse.
- Four moves to col 0 in 4x4 -> bits 0,4,8,12 set, owners 0,1,0,1; fifth move col 0 -> out_move_rej pulse, board unchanged, out_col_full=0001, turn unchanged.
- in_column=1111 and 1100 -> out_move_rej each, no board change.
- Hold enable high 10 cycles -> exactly one move written.
- in_game_status=01 in IDLE -> current_state=11, out_game_status=01; further enable pulses ignored; reset low -> all outputs zero.
- Fill all 16 cells with valid moves, in_game_status=00 -> out_game_status=11, state OVER after 16th write; repeat with ROWS=6, COLS=7 for 42 cells.

Source files
------------

// File: rtl/connect4_drop_ctrl.sv
// connect4_drop_ctrl: column-select / token-drop controller for a ROWS x COLS
// Connect4 board. A rising edge on enable starts a move into the column picked
// by in_column (active-low one-hot). The token lands in the lowest free cell of
// that column for the player whose turn it is, and then the turn passes.
// Malformed selects and full columns are rejected. A full board ends the game
// as a draw, and a result from the win checker freezes the board.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   enable                move strobe (rising edge triggers)
//   in_column [COLS]      active-low one-hot column select
//   in_game_status [2]    00 playing, 01 P1 won, 10 P2 won, 11 draw
//   out_gameboard [N]     occupancy, bit r*COLS+c
//   out_players_cells [N] owner, 1 = P2
//   out_game_status [2]   latched game status
//   current_state [2]     00 IDLE, 01 CALC, 10 PLACE, 11 OVER
//   playerTurn            0 = P1 to move, 1 = P2 to move
//   column_calc [CW]      cell index chosen / last written
//   out_move_ok           one-cycle pulse, token written
//   out_move_rej          one-cycle pulse, move rejected
//   out_col_full [COLS]   column holds ROWS tokens
module connect4_drop_ctrl #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [COLS-1:0]                  in_column,
  input  logic [1:0]                       in_game_status,
  output logic [ROWS*COLS-1:0]             out_gameboard,
  output logic [ROWS*COLS-1:0]             out_players_cells,
  output logic [1:0]                       out_game_status,
  output logic [1:0]                       current_state,
  output logic                             playerTurn,
  output logic [$clog2(ROWS*COLS)-1:0]     column_calc,
  output logic                             out_move_ok,
  output logic                             out_move_rej,
  output logic [COLS-1:0]                  out_col_full
);

  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned HW  = $clog2(ROWS + 1);
  localparam int unsigned MW  = $clog2(N + 1);
  localparam int unsigned CIW = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    PLACE = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t          state;
  logic            enable_d;
  logic [COLS-1:0] col_lat;
  logic [HW-1:0]   h [COLS];
  logic [MW-1:0]   moves;

  logic            enable_rise;
  logic            col_onehot;
  logic [CIW-1:0]  col_idx;
  logic [CW-1:0]   cell_c;

  assign enable_rise   = enable & ~enable_d;
  assign current_state = state;

  // Decode the latched select: the index of its zero bit, and whether exactly one bit is zero.
  always_comb begin
    col_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_lat[c]) col_idx = CIW'(c);
    end
    col_onehot = $onehot(~col_lat);
    cell_c     = CW'(h[col_idx]) * CW'(COLS) + CW'(col_idx);
  end

  // Column-full flags follow the height counters directly.
  always_comb begin
    out_col_full = '0;
    for (int c = 0; c < COLS; c++) begin
      out_col_full[c] = (h[c] == HW'(ROWS));
    end
  end

  // Move FSM with all board state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      enable_d          <= 1'b0;
      col_lat           <= '0;
      moves             <= '0;
      for (int c = 0; c < COLS; c++) h[c] <= '0;
      out_gameboard     <= '0;
      out_players_cells <= '0;
      out_game_status   <= 2'b00;
      playerTurn        <= 1'b0;
      column_calc       <= '0;
      out_move_ok       <= 1'b0;
      out_move_rej      <= 1'b0;
    end else begin
      // The edge history runs every cycle, so a rise seen outside IDLE is consumed.
      enable_d     <= enable;
      out_move_ok  <= 1'b0;
      out_move_rej <= 1'b0;
      case (state)
        IDLE: begin
          if (in_game_status != 2'b00) begin
            out_game_status <= in_game_status;
            state           <= OVER;
          end else if (enable_rise) begin
            col_lat <= in_column;
            state   <= CALC;
          end
        end
        CALC: begin
          if (in_game_status != 2'b00) begin
            out_game_status <= in_game_status;
            state           <= OVER;
          end else if (col_onehot && (h[col_idx] < HW'(ROWS))) begin
            column_calc <= cell_c;
            state       <= PLACE;
          end else begin
            out_move_rej <= 1'b1;
            state        <= IDLE;
          end
        end
        PLACE: begin
          out_gameboard[column_calc]     <= 1'b1;
          out_players_cells[column_calc] <= playerTurn;
          h[col_idx]                     <= h[col_idx] + HW'(1);
          moves                          <= moves + MW'(1);
          playerTurn                     <= ~playerTurn;
          out_move_ok                    <= 1'b1;
          // An external result takes precedence over a draw reached on the same move.
          if (in_game_status != 2'b00) begin
            out_game_status <= in_game_status;
            state           <= OVER;
          end else if (moves == MW'(N - 1)) begin
            out_game_status <= 2'b11;
            state           <= OVER;
          end else begin
            state <= IDLE;
          end
        end
        OVER:    state <= OVER;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_drop_ctrl.sv
// Directed bench for connect4_drop_ctrl: a 4x4 instance for most scenarios and
// a 6x7 instance for the large-board fill.
module tb_connect4_drop_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  in_column;
  logic [1:0]  in_game_status;
  logic [15:0] out_gameboard;
  logic [15:0] out_players_cells;
  logic [1:0]  out_game_status;
  logic [1:0]  current_state;
  logic        playerTurn;
  logic [3:0]  column_calc;
  logic        out_move_ok;
  logic        out_move_rej;
  logic [3:0]  out_col_full;

  logic        b_enable;
  logic [6:0]  b_in_column;
  logic [1:0]  b_in_game_status;
  logic [41:0] b_gameboard;
  logic [41:0] b_players_cells;
  logic [1:0]  b_game_status;
  logic [1:0]  b_state;
  logic        b_turn;
  logic [5:0]  b_column_calc;
  logic        b_move_ok;
  logic        b_move_rej;
  logic [6:0]  b_col_full;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  connect4_drop_ctrl #(.ROWS(4), .COLS(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_column(in_column),
    .in_game_status(in_game_status), .out_gameboard(out_gameboard),
    .out_players_cells(out_players_cells), .out_game_status(out_game_status),
    .current_state(current_state), .playerTurn(playerTurn),
    .column_calc(column_calc), .out_move_ok(out_move_ok),
    .out_move_rej(out_move_rej), .out_col_full(out_col_full)
  );

  connect4_drop_ctrl #(.ROWS(6), .COLS(7)) dut_big (
    .clk(clk), .reset(reset), .enable(b_enable), .in_column(b_in_column),
    .in_game_status(b_in_game_status), .out_gameboard(b_gameboard),
    .out_players_cells(b_players_cells), .out_game_status(b_game_status),
    .current_state(b_state), .playerTurn(b_turn),
    .column_calc(b_column_calc), .out_move_ok(b_move_ok),
    .out_move_rej(b_move_rej), .out_col_full(b_col_full)
  );

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b0;
    enable           = 1'b0;
    in_column        = 4'hF;
    in_game_status   = 2'b00;
    b_enable         = 1'b0;
    b_in_column      = 7'h7F;
    b_in_game_status = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One enable pulse on the 4x4 instance; counts pulses over the following four cycles.
  task automatic move(input logic [3:0] col, output int oks, output int rejs);
    oks  = 0;
    rejs = 0;
    in_column = col;
    enable    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) enable = 1'b0;
      if (out_move_ok)  oks++;
      if (out_move_rej) rejs++;
    end
  endtask

  task automatic b_move(input int c, output int oks);
    logic [6:0] sel;
    oks = 0;
    sel = 7'h7F;
    sel[c] = 1'b0;
    b_in_column = sel;
    b_enable    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) b_enable = 1'b0;
      if (b_move_ok) oks++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({out_gameboard, out_players_cells} !== 32'h0) $display("FAIL reset_board got %h/%h want 0", out_gameboard, out_players_cells); else passed++;
    total++; if ({out_game_status, current_state, playerTurn} !== 5'b0) $display("FAIL reset_state got st=%b cs=%b turn=%b want 0", out_game_status, current_state, playerTurn); else passed++;
    total++; if ({column_calc, out_move_ok, out_move_rej, out_col_full} !== 10'b0) $display("FAIL reset_misc got cc=%h ok=%b rej=%b full=%b want 0", column_calc, out_move_ok, out_move_rej, out_col_full); else passed++;
    do_reset();
  endtask

  task automatic test_first_move();
    int oks, rejs;
    move(4'b1110, oks, rejs);
    total++; if (out_gameboard !== 16'h0001) $display("FAIL first_board got %h want 0001", out_gameboard); else passed++;
    total++; if (out_players_cells !== 16'h0000) $display("FAIL first_owner got %h want 0000", out_players_cells); else passed++;
    total++; if (playerTurn !== 1'b1) $display("FAIL first_turn got %b want 1", playerTurn); else passed++;
    total++; if (oks !== 1 || rejs !== 0) $display("FAIL first_pulses got ok=%0d rej=%0d want 1/0", oks, rejs); else passed++;
    total++; if (current_state !== 2'b00 || column_calc !== 4'd0) $display("FAIL first_idle got cs=%b cc=%0d want 00/0", current_state, column_calc); else passed++;
  endtask

  task automatic test_column_fill();
    int oks, rejs, ok_sum;
    ok_sum = 0;
    for (int i = 0; i < 3; i++) begin
      move(4'b1110, oks, rejs);
      ok_sum += oks;
    end
    total++; if (ok_sum !== 3) $display("FAIL fill_oks got %0d want 3", ok_sum); else passed++;
    total++; if (out_gameboard !== 16'h1111 || out_players_cells !== 16'h1010) $display("FAIL fill_col got %h/%h want 1111/1010", out_gameboard, out_players_cells); else passed++;
    total++; if (column_calc !== 4'd12) $display("FAIL fill_calc got %0d want 12", column_calc); else passed++;
    total++; if (out_col_full !== 4'b0001) $display("FAIL fill_full got %b want 0001", out_col_full); else passed++;
    move(4'b1110, oks, rejs);
    total++; if (oks !== 0 || rejs !== 1) $display("FAIL full_rej got ok=%0d rej=%0d want 0/1", oks, rejs); else passed++;
    total++; if (out_gameboard !== 16'h1111 || playerTurn !== 1'b0) $display("FAIL full_nochange got %h turn=%b want 1111/0", out_gameboard, playerTurn); else passed++;
  endtask

  task automatic test_bad_select();
    int oks, rejs;
    move(4'b1111, oks, rejs);
    total++; if (oks !== 0 || rejs !== 1) $display("FAIL sel1111 got ok=%0d rej=%0d want 0/1", oks, rejs); else passed++;
    move(4'b1100, oks, rejs);
    total++; if (oks !== 0 || rejs !== 1) $display("FAIL sel1100 got ok=%0d rej=%0d want 0/1", oks, rejs); else passed++;
    total++; if (out_gameboard !== 16'h1111 || playerTurn !== 1'b0) $display("FAIL bad_nochange got %h turn=%b want 1111/0", out_gameboard, playerTurn); else passed++;
  endtask

  task automatic test_hold_enable();
    int oks;
    oks = 0;
    in_column = 4'b1101;
    enable    = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 9) enable = 1'b0;
      if (out_move_ok) oks++;
    end
    total++; if (oks !== 1) $display("FAIL hold_oks got %0d want 1", oks); else passed++;
    total++; if (out_gameboard !== 16'h1113 || out_players_cells !== 16'h1010) $display("FAIL hold_board got %h/%h want 1113/1010", out_gameboard, out_players_cells); else passed++;
    total++; if (playerTurn !== 1'b1) $display("FAIL hold_turn got %b want 1", playerTurn); else passed++;
  endtask

  task automatic test_status_over();
    int oks, rejs;
    in_game_status = 2'b01;
    @(negedge clk);
    in_game_status = 2'b00;
    total++; if (current_state !== 2'b11 || out_game_status !== 2'b01) $display("FAIL idle_over got cs=%b st=%b want 11/01", current_state, out_game_status); else passed++;
    move(4'b1011, oks, rejs);
    total++; if (oks !== 0 || out_gameboard !== 16'h1113 || current_state !== 2'b11) $display("FAIL over_frozen got ok=%0d %h cs=%b want 0/1113/11", oks, out_gameboard, current_state); else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({out_gameboard, out_players_cells, out_game_status, current_state, playerTurn} !== 37'b0) $display("FAIL over_reset got %h %h st=%b cs=%b turn=%b want 0", out_gameboard, out_players_cells, out_game_status, current_state, playerTurn); else passed++;
    do_reset();
    // Result arriving while the move is in CALC aborts it.
    in_column = 4'b1110;
    enable    = 1'b1;
    @(negedge clk);
    enable         = 1'b0;
    in_game_status = 2'b10;
    @(negedge clk);
    in_game_status = 2'b00;
    oks = 0;
    if (out_move_ok) oks++;
    @(negedge clk);
    if (out_move_ok) oks++;
    total++; if (current_state !== 2'b11 || out_game_status !== 2'b10 || out_gameboard !== 16'h0 || oks !== 0) $display("FAIL calc_abort got cs=%b st=%b %h ok=%0d want 11/10/0/0", current_state, out_game_status, out_gameboard, oks); else passed++;
    do_reset();
  endtask

  task automatic test_fill_board();
    int oks, rejs, ok_sum;
    ok_sum = 0;
    for (int k = 0; k < 15; k++) begin
      move(~(4'b0001 << (k % 4)), oks, rejs);
      ok_sum += oks;
    end
    total++; if (current_state !== 2'b00 || out_game_status !== 2'b00 || out_col_full !== 4'b0111) $display("FAIL fill15 got cs=%b st=%b full=%b want 00/00/0111", current_state, out_game_status, out_col_full); else passed++;
    move(4'b0111, oks, rejs);
    ok_sum += oks;
    total++; if (ok_sum !== 16) $display("FAIL fill16_oks got %0d want 16", ok_sum); else passed++;
    total++; if (out_gameboard !== 16'hFFFF || out_players_cells !== 16'hAAAA) $display("FAIL fill16_board got %h/%h want ffff/aaaa", out_gameboard, out_players_cells); else passed++;
    total++; if (current_state !== 2'b11 || out_game_status !== 2'b11 || out_col_full !== 4'b1111) $display("FAIL fill16_draw got cs=%b st=%b full=%b want 11/11/1111", current_state, out_game_status, out_col_full); else passed++;
  endtask

  task automatic test_big_board();
    int oks, ok_sum;
    logic [41:0] exp_p;
    ok_sum = 0;
    exp_p  = '0;
    for (int k = 0; k < 42; k++) begin
      exp_p[k] = k[0];
      b_move(k % 7, oks);
      ok_sum += oks;
      if (k == 40) begin
        total++; if (b_state !== 2'b00 || b_game_status !== 2'b00) $display("FAIL big41 got cs=%b st=%b want 00/00", b_state, b_game_status); else passed++;
      end
    end
    total++; if (ok_sum !== 42) $display("FAIL big_oks got %0d want 42", ok_sum); else passed++;
    total++; if (b_gameboard !== {42{1'b1}} || b_players_cells !== exp_p) $display("FAIL big_board got %h/%h want all/%h", b_gameboard, b_players_cells, exp_p); else passed++;
    total++; if (b_state !== 2'b11 || b_game_status !== 2'b11 || b_col_full !== 7'h7F) $display("FAIL big_draw got cs=%b st=%b full=%b want 11/11/1111111", b_state, b_game_status, b_col_full); else passed++;
  endtask

  initial begin
    reset            = 1'b1;
    enable           = 1'b0;
    in_column        = 4'hF;
    in_game_status   = 2'b00;
    b_enable         = 1'b0;
    b_in_column      = 7'h7F;
    b_in_game_status = 2'b00;
    test_reset();
    test_first_move();
    test_column_fill();
    test_bad_select();
    test_hold_enable();
    test_status_over();
    test_fill_board();
    do_reset();
    test_big_board();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
